// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 2:1 mux select arbiter.
// Contents: FSM state encoding and the default tenure limit.
package mux_arb_pkg;

    localparam int unsigned HOLD_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_e;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two mux sources and the select arbiter.
//   req[1:0]  requester -> arbiter  per-source path request
//   lock      requester -> arbiter  hold current owner (only with MUX_ARB_LOCK_EN)
//   grant[1:0] arbiter -> requester one-hot or zero path ownership
//   sel       arbiter -> mux        1 selects D[1]
//   busy      arbiter -> requester  grant is nonzero
//   switch_p  arbiter -> requester  one-cycle pulse when sel changes
// Optional macro: MUX_ARB_LOCK_EN adds the lock signal.
interface mux_sel_arbiter_if;
    logic [1:0] req;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;
`endif
    logic [1:0] grant;
    logic       sel;
    logic       busy;
    logic       switch_p;

`ifdef MUX_ARB_LOCK_EN
    modport master (output req, output lock, input grant, input sel, input busy, input switch_p);
    modport slave  (input req, input lock, output grant, output sel, output busy, output switch_p);
`else
    modport master (output req, input grant, input sel, input busy, input switch_p);
    modport slave  (input req, output grant, output sel, output busy, output switch_p);
`endif
endinterface

// File: rtl/mux_arb_hold_cnt.sv
// Saturating tenure counter for the select arbiter.
//   clk, rst_n  clock and async active-low reset
//   clear       restart tenure at 0 (new owner)
//   enable      owner kept the path this cycle
//   freeze      hold the count (locked transfer)
//   at_limit    registered: count equals HOLD_CYCLES-1
module mux_arb_hold_cnt #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic freeze,
    output logic at_limit
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // Next count: clear wins, otherwise count up until saturation.
    always_comb begin
        cnt_nx = cnt;
        if (clear) begin
            cnt_nx = '0;
        end else if (enable && !freeze && (cnt != LIMIT)) begin
            cnt_nx = cnt + CNT_W'(1);
        end
    end

    // Limit flag is registered alongside the count so the FSM sees a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            at_limit <= (LIMIT == '0);
        end else begin
            cnt      <= cnt_nx;
            at_limit <= (cnt_nx == LIMIT);
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter producing the select for a 2:1 data mux.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   arb    mux_sel_arbiter_if.slave: req/lock in, grant/sel/busy/switch_p out
// Optional macro: MUX_ARB_LOCK_EN enables the lock input that pins the current owner.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_sel_arbiter_if.slave   arb
);

    state_e     state;
    state_e     state_nx;
    logic       last;
    logic       last_nx;
    logic       sel_q;
    logic       sel_nx;
    logic [1:0] grant_q;
    logic       busy_q;
    logic       switch_q;
    logic       at_limit;
    logic       lock_c;
    logic       cnt_clr_c;
    logic       cnt_en_c;

`ifdef MUX_ARB_LOCK_EN
    assign lock_c = arb.lock;
`else
    assign lock_c = 1'b0;
`endif

    // Next-state: last records the most recent owner that gave up the path.
    always_comb begin
        state_nx = state;
        last_nx  = last;
        case (state)
            ST_IDLE: begin
                case (arb.req)
                    2'b01:   state_nx = ST_G0;
                    2'b10:   state_nx = ST_G1;
                    2'b11:   state_nx = last ? ST_G0 : ST_G1;
                    default: state_nx = ST_IDLE;
                endcase
            end
            ST_G0: begin
                if (!arb.req[0]) begin
                    last_nx  = 1'b0;
                    state_nx = arb.req[1] ? ST_G1 : ST_IDLE;
                end else if (arb.req[1] && at_limit && !lock_c) begin
                    last_nx  = 1'b0;
                    state_nx = ST_G1;
                end
            end
            ST_G1: begin
                if (!arb.req[1]) begin
                    last_nx  = 1'b1;
                    state_nx = arb.req[0] ? ST_G0 : ST_IDLE;
                end else if (arb.req[0] && at_limit && !lock_c) begin
                    last_nx  = 1'b1;
                    state_nx = ST_G0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // sel follows the granted source and holds through IDLE.
    always_comb begin
        sel_nx = sel_q;
        if (state_nx == ST_G0) begin
            sel_nx = 1'b0;
        end else if (state_nx == ST_G1) begin
            sel_nx = 1'b1;
        end
    end

    // Tenure restarts on any entry into a grant state, counts while the owner stays.
    assign cnt_clr_c = (state_nx != ST_IDLE) && (state_nx != state);
    assign cnt_en_c  = (state != ST_IDLE) && (state_nx == state);

    mux_arb_hold_cnt #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clr_c),
        .enable   (cnt_en_c),
        .freeze   (lock_c),
        .at_limit (at_limit)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            grant_q  <= 2'b00;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            grant_q  <= {state_nx == ST_G1, state_nx == ST_G0};
            sel_q    <= sel_nx;
            busy_q   <= (state_nx != ST_IDLE);
            switch_q <= (sel_nx != sel_q);
        end
    end

    assign arb.grant    = grant_q;
    assign arb.sel      = sel_q;
    assign arb.busy     = busy_q;
    assign arb.switch_p = switch_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter (HOLD_CYCLES=4 and HOLD_CYCLES=1 instances).
// Build with MUX_ARB_LOCK_EN defined to also exercise the lock input.
module tb_mux_sel_arbiter;
    import mux_arb_pkg::*;

    typedef struct packed {
        logic [1:0] grant;
        logic       sel;
        logic       busy;
        logic       sw;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;
    logic [7:0] y;
    obs_t       sb_q[$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter_if ifa ();
    mux_sel_arbiter_if ifb ();

    mux_sel_arbiter #(.HOLD_CYCLES(4)) dut_a (.clk(clk), .rst_n(rst_n), .arb(ifa.slave));
    mux_sel_arbiter #(.HOLD_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .arb(ifb.slave));

    // The 2:1 data mux driven by the arbiter select.
    assign y = ifa.sel ? d1 : d0;

    function automatic obs_t mk(input logic [1:0] g, input logic s, input logic sw);
        obs_t o;
        o.grant = g;
        o.sel   = s;
        o.busy  = (g != 2'b00);
        o.sw    = sw;
        return o;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        ifa.req = 2'b00;
        ifb.req = 2'b00;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got;
        #3;
        got = {ifa.grant, ifa.sel, ifa.busy, ifa.switch_p};
        total++;
        if (got !== mk(2'b00, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_a got=%b want=%b", got, mk(2'b00, 1'b0, 1'b0));
        end
        got = {ifb.grant, ifb.sel, ifb.busy, ifb.switch_p};
        total++;
        if (got !== mk(2'b00, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_b got=%b want=%b", got, mk(2'b00, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        obs_t got, exp;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ifa.req = (k < 4) ? 2'b01 : 2'b00;
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            sb_q.push_back(mk((k < 4) ? 2'b01 : 2'b00, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = {ifa.grant, ifa.sel, ifa.busy, ifa.switch_p};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL single[%0d] got=%b want=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_idle_hold();
        logic [1:0] rq[6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11};
        obs_t       ex[6];
        obs_t       got, exp;
        ex = '{mk(2'b10, 1'b1, 1'b1), mk(2'b00, 1'b1, 1'b0), mk(2'b00, 1'b1, 1'b0),
               mk(2'b10, 1'b1, 1'b0), mk(2'b00, 1'b1, 1'b0), mk(2'b01, 1'b0, 1'b1)};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ifa.req = rq[k];
            sb_q.push_back(ex[k]);
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = {ifa.grant, ifa.sel, ifa.busy, ifa.switch_p};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL idle_hold[%0d] got=%b want=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_contention();
        obs_t       got, exp;
        logic [1:0] g;
        logic       s;
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            if (k < 14) begin
                ifa.req = 2'b11;
                s = ((k / 4) % 2) == 1;
                g = s ? 2'b10 : 2'b01;
                sb_q.push_back(mk(g, s, (k % 4 == 0) && (k > 0)));
            end else if (k < 16) begin
                ifa.req = 2'b01;
                sb_q.push_back(mk(2'b01, 1'b0, k == 14));
            end else begin
                ifa.req = 2'b00;
                sb_q.push_back(mk(2'b00, 1'b0, 1'b0));
            end
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = {ifa.grant, ifa.sel, ifa.busy, ifa.switch_p};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL contention[%0d] got=%b want=%b", k, got, exp);
            end
            total++;
            if (y !== (exp.sel ? d1 : d0)) begin
                bad++;
                $display("FAIL mux_y[%0d] got=%h want=%h", k, y, exp.sel ? d1 : d0);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ifa.req = 2'b10;
            sb_q.push_back(mk(2'b10, 1'b1, k == 0));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = {ifa.grant, ifa.sel, ifa.busy, ifa.switch_p};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL pre_reset[%0d] got=%b want=%b", k, got, exp);
            end
        end
        @(negedge clk);
        ifa.req = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        got = {ifa.grant, ifa.sel, ifa.busy, ifa.switch_p};
        total++;
        if (got !== mk(2'b00, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", got, mk(2'b00, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(mk(2'b01, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        got = {ifa.grant, ifa.sel, ifa.busy, ifa.switch_p};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL post_reset got=%b want=%b", got, exp);
        end
        @(negedge clk);
        ifa.req = 2'b00;
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        obs_t got, exp;
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k < 4) begin
                ifa.req = 2'b11; ifa.lock = 1'b0;
                sb_q.push_back(mk(2'b01, 1'b0, 1'b0));
            end else if (k < 14) begin
                ifa.req = 2'b11; ifa.lock = 1'b1;
                sb_q.push_back(mk(2'b01, 1'b0, 1'b0));
            end else if (k == 14) begin
                ifa.req = 2'b11; ifa.lock = 1'b0;
                sb_q.push_back(mk(2'b10, 1'b1, 1'b1));
            end else begin
                ifa.req = 2'b01; ifa.lock = 1'b1;
                sb_q.push_back(mk(2'b01, 1'b0, 1'b1));
            end
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = {ifa.grant, ifa.sel, ifa.busy, ifa.switch_p};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL lock[%0d] got=%b want=%b", k, got, exp);
            end
        end
        @(negedge clk);
        ifa.req  = 2'b00;
        ifa.lock = 1'b0;
    endtask
`endif

    task automatic test_hold1();
        obs_t got, exp;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ifb.req = 2'b11;
            sb_q.push_back(mk((k % 2 == 1) ? 2'b10 : 2'b01, k % 2 == 1, k > 0));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = {ifb.grant, ifb.sel, ifb.busy, ifb.switch_p};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL hold1[%0d] got=%b want=%b", k, got, exp);
            end
        end
        @(negedge clk);
        ifb.req = 2'b00;
    endtask

    initial begin
        ifa.req = 2'b00;
        ifb.req = 2'b00;
`ifdef MUX_ARB_LOCK_EN
        ifa.lock = 1'b0;
        ifb.lock = 1'b0;
`endif
        #1 rst_n = 1'b0;
        test_reset();
        test_single();
        test_idle_hold();
        test_contention();
        test_reset_mid();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        test_hold1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
